// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : main control FSM for the multicycle MIPS datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDIEXEC = 4'd11,
    S_ADDIWB   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

  always_comb begin
    w_next      = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        // PC+4 and IR load only commit on the cycle memory delivers the word
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          w_next = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          w_next = S_EXECUTE;
        end else if (opcode == OP_BEQ) begin
          w_next = S_BRANCH;
        end else if (opcode == OP_J) begin
          w_next = S_JUMP;
        end else if (opcode == OP_ADDI) begin
          w_next = S_ADDIEXEC;
        end else begin
          illegal_op = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : instruction-level model checks every cycle of the FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
  logic [16:0] w_act;
  assign w_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Control word the datapath must see in a given step of an instruction
  function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic mr,
                                           input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    {asb, aop, pcs} = '0;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  begin asb = 2'b11;
                   ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b000010, 6'b001000}); end
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin m2r = 1; rw = 1; end
      4'd6:  begin mwr = 1; iord = 1; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rdst = 1; rw = 1; end
      4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd10: begin pcw = 1; pcs = 2'b10; end
      4'd11: begin asa = 1; asb = 2'b10; end
      4'd12: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (state !== e.st || w_act !== e.o) begin
        n_err++;
        $display("FAIL cycle t=%0t: state=%0d ctl=%b, required state=%0d ctl=%b",
                 $time, state, w_act, e.st, e.o);
      end
    end
  end

  task automatic push_idle_cycle();
    exp_t e;
    @(negedge clk);
    e.st = 4'd0;
    e.o  = '0;
    exp_q.push_back(e);
  endtask

  // Builds the step list of one instruction from its cycle-count rules;
  // mq entry 2 marks a cycle where mem_ready must not matter.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int exp_len, input int trunc);
    int   sq[$];
    int   mq[$];
    int   n;
    exp_t e;
    for (int i = 0; i < fw; i++) begin sq.push_back(1); mq.push_back(0); end
    sq.push_back(1); mq.push_back(1);
    sq.push_back(2); mq.push_back(2);
    case (op)
      6'b100011: begin
        sq.push_back(3); mq.push_back(2);
        for (int i = 0; i < mw; i++) begin sq.push_back(4); mq.push_back(0); end
        sq.push_back(4); mq.push_back(1);
        sq.push_back(5); mq.push_back(2);
      end
      6'b101011: begin
        sq.push_back(3); mq.push_back(2);
        for (int i = 0; i < mw; i++) begin sq.push_back(6); mq.push_back(0); end
        sq.push_back(6); mq.push_back(1);
      end
      6'b000000: begin sq.push_back(7);  mq.push_back(2); sq.push_back(8);  mq.push_back(2); end
      6'b000100: begin sq.push_back(9);  mq.push_back(2); end
      6'b000010: begin sq.push_back(10); mq.push_back(2); end
      6'b001000: begin sq.push_back(11); mq.push_back(2); sq.push_back(12); mq.push_back(2); end
      default: ;
    endcase
    if (trunc == 0) begin
      n_vec++;
      if (sq.size() != exp_len + fw + mw) begin
        n_err++;
        $display("FAIL cycle count op=%b: model=%0d, required=%0d", op, sq.size(),
                 exp_len + fw + mw);
      end
    end
    n = (trunc == 0) ? sq.size() : trunc;
    for (int i = 0; i < n; i++) begin
      logic mr;
      @(negedge clk);
      mr = (mq[i] == 2) ? i[0] : mq[i][0];
      opcode    = op;
      mem_ready = mr;
      e.st = sq[i][3:0];
      e.o  = exp_outs(sq[i][3:0], mr, op);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b0;
    push_idle_cycle();
    push_idle_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    e.st = 4'd0; e.o = '0;
    exp_q.push_back(e);

    run_instr(6'b000000, 0, 0, 4, 0);   // R-type
    run_instr(6'b100011, 0, 2, 5, 0);   // lw with 2 wait cycles
    run_instr(6'b001000, 3, 0, 4, 0);   // addi behind 3-cycle fetch wait
    run_instr(6'b000100, 0, 0, 3, 0);   // beq
    run_instr(6'b000010, 0, 0, 3, 0);   // j
    run_instr(6'b101011, 0, 1, 4, 0);   // sw with 1 wait cycle
    run_instr(6'b111111, 0, 0, 2, 0);   // illegal opcode
    run_instr(6'b100011, 0, 0, 5, 0);   // lw, no wait
    run_instr(6'b101011, 0, 0, 4, 0);   // sw, no wait
    run_instr(6'b010101, 1, 0, 2, 0);   // another illegal opcode

    // Stop an sw while MemWrite is pending, then assert reset between edges
    run_instr(6'b101011, 0, 6, 4, 5);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd0 || MemWrite !== 1'b0 || w_act !== 17'd0) begin
      n_err++;
      $display("FAIL async reset: state=%0d MemWrite=%b ctl=%b, required 0 0 0",
               state, MemWrite, w_act);
    end
    push_idle_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    e.st = 4'd0; e.o = '0;
    exp_q.push_back(e);

    run_instr(6'b000000, 0, 0, 4, 0);
    run_instr(6'b001000, 0, 0, 4, 0);
    @(negedge clk);
    opcode = 6'b000000;
    mem_ready = 1'b0;
    e.st = 4'd1; e.o = exp_outs(4'd1, 1'b0, 6'b000000);
    exp_q.push_back(e);
    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
